branch_sequencer: RTL and testbench
===================================

Name: branch_sequencer

Overview:
- Control-side sequencer for the conditional branch instruction (br with C2 condition field).
- The main control unit launches it once T0–T2 fetch is complete. It then generates the T3–T6 control strobes that:
  - load the condition flip-flop from Ra;
  - compute PC + sign-extended C;
  - write PC only when the latched condition (CON) is true.
- It drives the CON flip-flop's ConIn and consumes that flip-flop's output, so it forms the other end of the CON interface.
- It also keeps a taken-branch count for debug and reports malformed launches.

Parameters:
- BR_OPCODE, 5'b10010, opcode value in ir[31:27] accepted as a branch.
- CNT_W, 16, width of the taken-branch counter.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- clr  input  1  asynchronous, active-high reset.
- start  input  1  one-cycle launch pulse from the main control unit; ir is valid in that cycle.
- ir  input  32  instruction register contents.
- con_in  input  1  registered output of the CON flip-flop.
- busy  output  1  high from the cycle after an accepted start through the DONE state.
- done  output  1  one-cycle pulse in the DONE state.
- Gra  output  1  select the Ra field for register-file read.
- Rout  output  1  register file drives the bus.
- ConIn  output  1  CON flip-flop load enable.
- PCout  output  1  PC drives the bus.
- Yin  output  1  Y register load.
- Cout  output  1  sign-extended ir[18:0] drives the bus.
- alu_add  output  1  ALU operation select = ADD.
- Zin  output  1  Z register load.
- Zlowout  output  1  Zlow drives the bus.
- PCin  output  1  PC load.
- taken  output  1  registered; result of the last completed branch.
- taken_cnt  output  CNT_W  number of taken branches; saturates at all-ones.
- illegal  output  1  sticky; set when start arrives with ir[31:27] != BR_OPCODE.

Behaviour:
- Reset (clr=1, asynchronous):
  - state = IDLE; every strobe, busy, done, taken and illegal = 0; taken_cnt = 0.
  - Asserting clr mid-sequence aborts immediately. No PCin is issued, and the counter is unchanged except that it clears.
- All strobes are decoded from the registered state, i.e. Moore outputs. At most the listed strobes are high in each state; all others are 0.
- States and strobes:
  - IDLE: no strobes.
    - start=1 with valid opcode -> T3.
    - start=1 with bad opcode -> set illegal; stay in IDLE.
    - start=0 -> stay in IDLE.
  - T3: Gra, Rout, ConIn -> T4.
  - T4: PCout, Yin -> T5.
  - T5: Cout, alu_add, Zin -> T6.
  - T6: Zlowout, plus PCin = con_in (combinational gate on con_in in this state only) -> DONE.
  - DONE: done=1 -> IDLE.
- Timing of the CON path:
  - The CON flip-flop has two register stages: condition captured at the end of T3, con_in valid from T5 onward.
  - Sampling con_in in T6 is therefore required.
  - con_in in any other state is ignored.
- taken: loaded with con_in at the end of T6; holds until the next T6 or clr.
- taken_cnt: increments by 1 at the end of T6 when con_in=1. Held at 2^CNT_W−1 once reached; no wrap.
- start handling:
  - start while busy=1 is ignored: no restart and no illegal flag.
  - Back-to-back operation is allowed: start in the same cycle as IDLE entered from DONE is accepted.
- illegal is sticky; only clr clears it.
- Latency: start accepted at edge N; T3 strobes visible in cycle N+1; PCin (if taken) in cycle N+4; done in cycle N+5.
- ir is sampled only at start. The condition field ir[20:19] is owned by the CON flip-flop; this block does not decode it.

Decomposition:
- Shared package: BR_OPCODE, the state encoding (IDLE, T3, T4, T5, T6, DONE as 3-bit localparams), and the strobe-vector bit positions. These are reused by the main control unit.
- One natural sub-module: sat_counter (CNT_W-wide saturating incrementer with enable and async clr), instantiated for taken_cnt.

Test Plan:
- Reset then idle:
  - Stimulus: clr pulse, then 10 idle cycles.
  - Required: all outputs 0, taken_cnt = 0, state stays IDLE.
- Taken branch:
  - Stimulus: ir = {5'b10010, Ra=4'd3, 4'b0000, 19'd35}, start pulse; con_in driven 1 from T5.
  - Required: strobes follow T3→T6 in cycles N+1…N+4; PCin=1 in N+4; done in N+5; taken=1; taken_cnt=1.
- Not-taken branch:
  - Stimulus: same launch as above, con_in=0.
  - Required: PCin never asserted; Zlowout still asserted in T6; taken=0; taken_cnt unchanged.
- Protocol edges:
  - start asserted during T4 -> ignored, sequence unchanged.
  - start in the cycle after DONE -> new T3 next cycle.
  - start with ir[31:27] = 5'b00011 -> illegal=1, busy stays 0.
- Mid-sequence reset and saturation:
  - clr asserted asynchronously during T5 -> all strobes drop immediately, no PCin.
  - Preload via 2^CNT_W taken branches (CNT_W=4 override) -> taken_cnt holds at 15.

Source files
------------

// File: rtl/branch_sequencer_pkg.sv
// Shared definitions for the conditional-branch sequencer: opcode, state
// encoding and strobe-vector bit positions, reused by the main control unit.
package branch_sequencer_pkg;

   localparam logic [4:0] BR_OPCODE = 5'b10010;

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_T3   = 3'd1,
      S_T4   = 3'd2,
      S_T5   = 3'd3,
      S_T6   = 3'd4,
      S_DONE = 3'd5
   } br_state_t;

   localparam int unsigned STB_GRA     = 0;
   localparam int unsigned STB_ROUT    = 1;
   localparam int unsigned STB_CONIN   = 2;
   localparam int unsigned STB_PCOUT   = 3;
   localparam int unsigned STB_YIN     = 4;
   localparam int unsigned STB_COUT    = 5;
   localparam int unsigned STB_ALU_ADD = 6;
   localparam int unsigned STB_ZIN     = 7;
   localparam int unsigned STB_ZLOWOUT = 8;
   localparam int unsigned STB_PCIN    = 9;
   localparam int unsigned NUM_STB     = 10;

   function automatic logic is_branch(input logic [4:0] opcode, input logic [4:0] br_op);
      return opcode == br_op;
   endfunction

endpackage

// File: rtl/branch_sequencer_if.sv
// Control-unit <-> branch sequencer connection: launch handshake, CON
// flip-flop link, datapath strobes and debug status.
interface branch_sequencer_if #(
   parameter int unsigned CNT_W = 16
);
   logic             start;
   logic [31:0]      ir;
   logic             con_in;
   logic             busy;
   logic             done;
   logic             Gra;
   logic             Rout;
   logic             ConIn;
   logic             PCout;
   logic             Yin;
   logic             Cout;
   logic             alu_add;
   logic             Zin;
   logic             Zlowout;
   logic             PCin;
   logic             taken;
   logic [CNT_W-1:0] taken_cnt;
   logic             illegal;

   modport master (
      output start, ir, con_in,
      input  busy, done, Gra, Rout, ConIn, PCout, Yin, Cout, alu_add, Zin,
             Zlowout, PCin, taken, taken_cnt, illegal
   );

   modport slave (
      input  start, ir, con_in,
      output busy, done, Gra, Rout, ConIn, PCout, Yin, Cout, alu_add, Zin,
             Zlowout, PCin, taken, taken_cnt, illegal
   );
endinterface

// File: rtl/branch_sequencer_sat_counter.sv
// W-bit up-counter with enable that sticks at all-ones instead of wrapping.
module sat_counter #(
   parameter int unsigned W = 16
) (
   input  logic         clk,
   input  logic         clr,
   input  logic         en,
   output logic [W-1:0] count
);
   logic [W-1:0] one;

   assign one = {{(W-1){1'b0}}, 1'b1};

   always_ff @(posedge clk or posedge clr) begin
      if (clr)
         count <= '0;
      else if (en && (count != '1))
         count <= count + one;
   end
endmodule

// File: rtl/branch_sequencer.sv
// Sequencer for the conditional branch: emits the T3..T6 Moore strobes after
// fetch, gates PCin with the CON flip-flop, and tracks taken/illegal status.
module branch_sequencer
   import branch_sequencer_pkg::*;
#(
   parameter logic [4:0]  BR_OPCODE = branch_sequencer_pkg::BR_OPCODE,
   parameter int unsigned CNT_W     = 16
) (
   input logic               clk,
   input logic               clr,
   branch_sequencer_if.slave bus
);
   br_state_t          state, state_nxt;
   logic [NUM_STB-1:0] stb;
   logic               illegal_set;
   logic               taken_q;
   logic               illegal_q;
   logic               cnt_en;
   logic [CNT_W-1:0]   cnt;

   always_ff @(posedge clk or posedge clr) begin
      if (clr)
         state <= S_IDLE;
      else
         state <= state_nxt;
   end

   // start outside IDLE is dropped here, so it can neither restart nor flag illegal.
   always_comb begin
      state_nxt   = state;
      illegal_set = 1'b0;
      stb         = '0;
      unique case (state)
         S_IDLE: begin
            if (bus.start) begin
               if (is_branch(bus.ir[31:27], BR_OPCODE))
                  state_nxt = S_T3;
               else
                  illegal_set = 1'b1;
            end
         end
         S_T3: begin
            stb[STB_GRA]   = 1'b1;
            stb[STB_ROUT]  = 1'b1;
            stb[STB_CONIN] = 1'b1;
            state_nxt      = S_T4;
         end
         S_T4: begin
            stb[STB_PCOUT] = 1'b1;
            stb[STB_YIN]   = 1'b1;
            state_nxt      = S_T5;
         end
         S_T5: begin
            stb[STB_COUT]    = 1'b1;
            stb[STB_ALU_ADD] = 1'b1;
            stb[STB_ZIN]     = 1'b1;
            state_nxt        = S_T6;
         end
         S_T6: begin
            stb[STB_ZLOWOUT] = 1'b1;
            stb[STB_PCIN]    = bus.con_in;
            state_nxt        = S_DONE;
         end
         S_DONE:  state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         taken_q   <= 1'b0;
         illegal_q <= 1'b0;
      end else begin
         if (state == S_T6)
            taken_q <= bus.con_in;
         if (illegal_set)
            illegal_q <= 1'b1;
      end
   end

   assign cnt_en = (state == S_T6) && bus.con_in;

   sat_counter #(.W(CNT_W)) u_taken_cnt (
      .clk   (clk),
      .clr   (clr),
      .en    (cnt_en),
      .count (cnt)
   );

   assign bus.busy      = (state != S_IDLE);
   assign bus.done      = (state == S_DONE);
   assign bus.Gra       = stb[STB_GRA];
   assign bus.Rout      = stb[STB_ROUT];
   assign bus.ConIn     = stb[STB_CONIN];
   assign bus.PCout     = stb[STB_PCOUT];
   assign bus.Yin       = stb[STB_YIN];
   assign bus.Cout      = stb[STB_COUT];
   assign bus.alu_add   = stb[STB_ALU_ADD];
   assign bus.Zin       = stb[STB_ZIN];
   assign bus.Zlowout   = stb[STB_ZLOWOUT];
   assign bus.PCin      = stb[STB_PCIN];
   assign bus.taken     = taken_q;
   assign bus.taken_cnt = cnt;
   assign bus.illegal   = illegal_q;
endmodule

// File: tb/tb_branch_sequencer.sv
// Directed bench for branch_sequencer: a default-width instance and a 4-bit
// counter instance share the same stimulus.
module tb_branch_sequencer;
   logic        clk;
   logic        clr;
   logic        start;
   logic [31:0] ir;
   logic        con_in;

   int n_cmp;
   int n_err;
   int exp_cnt;
   logic exp_ill;

   localparam logic [31:0] IR_BR  = {5'b10010, 4'd3, 4'b0000, 19'd35};
   localparam logic [31:0] IR_BAD = {5'b00011, 4'd3, 4'b0000, 19'd35};

   localparam logic [9:0] P_IDLE = 10'b0000000000;
   localparam logic [9:0] P_T3   = 10'b1110000000;
   localparam logic [9:0] P_T4   = 10'b0001100000;
   localparam logic [9:0] P_T5   = 10'b0000011100;

   branch_sequencer_if #(.CNT_W(16)) bif ();
   branch_sequencer_if #(.CNT_W(4))  bif4 ();

   assign bif.start   = start;
   assign bif.ir      = ir;
   assign bif.con_in  = con_in;
   assign bif4.start  = start;
   assign bif4.ir     = ir;
   assign bif4.con_in = con_in;

   branch_sequencer #(.CNT_W(16)) dut (
      .clk (clk),
      .clr (clr),
      .bus (bif.slave)
   );

   branch_sequencer #(.CNT_W(4)) dut4 (
      .clk (clk),
      .clr (clr),
      .bus (bif4.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [9:0] stb16();
      return {bif.Gra, bif.Rout, bif.ConIn, bif.PCout, bif.Yin, bif.Cout,
              bif.alu_add, bif.Zin, bif.Zlowout, bif.PCin};
   endfunction

   function automatic logic [9:0] stb4();
      return {bif4.Gra, bif4.Rout, bif4.ConIn, bif4.PCout, bif4.Yin, bif4.Cout,
              bif4.alu_add, bif4.Zin, bif4.Zlowout, bif4.PCin};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Launch one branch from IDLE and follow it through DONE back to IDLE.
   task automatic run_branch(input logic cv, input logic poke_t4);
      logic [9:0] p_t6;
      int exp4;
      p_t6    = {9'b000000001, cv};
      start   = 1'b1;
      ir      = IR_BR;
      con_in  = ~cv;
      tick();
      start = 1'b0;
      n_cmp++;
      if (stb16() !== P_T3 || bif.busy !== 1'b1) begin
         n_err++;
         $display("FAIL t3_strobes: got %b busy %b, want %b busy 1", stb16(), bif.busy, P_T3);
      end
      tick();
      n_cmp++;
      if (stb16() !== P_T4 || bif.busy !== 1'b1 || bif.done !== 1'b0) begin
         n_err++;
         $display("FAIL t4_strobes: got %b busy %b done %b, want %b busy 1 done 0",
                  stb16(), bif.busy, bif.done, P_T4);
      end
      if (poke_t4) begin
         start = 1'b1;
         ir    = IR_BAD;
      end
      tick();
      start  = 1'b0;
      ir     = IR_BR;
      con_in = cv;
      n_cmp++;
      if (stb16() !== P_T5 || bif.illegal !== exp_ill) begin
         n_err++;
         $display("FAIL t5_strobes: got %b illegal %b, want %b illegal %b",
                  stb16(), bif.illegal, P_T5, exp_ill);
      end
      tick();
      n_cmp++;
      if (stb16() !== p_t6) begin
         n_err++;
         $display("FAIL t6_strobes: got %b, want %b", stb16(), p_t6);
      end
      if (cv && exp_cnt < 65535) exp_cnt++;
      exp4 = (exp_cnt > 15) ? 15 : exp_cnt;
      tick();
      con_in = ~cv;
      n_cmp++;
      if (stb16() !== P_IDLE || bif.done !== 1'b1 || bif.busy !== 1'b1 ||
          bif.taken !== cv) begin
         n_err++;
         $display("FAIL done_state: got stb %b done %b busy %b taken %b, want %b 1 1 %b",
                  stb16(), bif.done, bif.busy, bif.taken, P_IDLE, cv);
      end
      n_cmp++;
      if (bif.taken_cnt !== 16'(exp_cnt)) begin
         n_err++;
         $display("FAIL taken_cnt: got %0d, want %0d", bif.taken_cnt, exp_cnt);
      end
      n_cmp++;
      if (bif4.taken_cnt !== 4'(exp4) || stb4() !== P_IDLE || bif4.done !== 1'b1) begin
         n_err++;
         $display("FAIL cnt4: got %0d stb %b done %b, want %0d %b 1",
                  bif4.taken_cnt, stb4(), bif4.done, exp4, P_IDLE);
      end
      tick();
      n_cmp++;
      if (bif.busy !== 1'b0 || bif.done !== 1'b0 || stb16() !== P_IDLE) begin
         n_err++;
         $display("FAIL back_to_idle: got busy %b done %b stb %b, want 0 0 %b",
                  bif.busy, bif.done, stb16(), P_IDLE);
      end
   endtask

   task automatic test_reset();
      start  = 1'b0;
      ir     = '0;
      con_in = 1'b1;
      clr    = 1'b1;
      #13;
      clr = 1'b0;
      exp_cnt = 0;
      exp_ill = 1'b0;
      for (int i = 0; i < 10; i++) begin
         tick();
         n_cmp++;
         if (stb16() !== P_IDLE || bif.busy !== 1'b0 || bif.done !== 1'b0 ||
             bif.taken !== 1'b0 || bif.illegal !== 1'b0 || bif.taken_cnt !== 16'd0) begin
            n_err++;
            $display("FAIL reset_idle[%0d]: got stb %b busy %b done %b taken %b ill %b cnt %0d, want all 0",
                     i, stb16(), bif.busy, bif.done, bif.taken, bif.illegal, bif.taken_cnt);
         end
      end
   endtask

   task automatic test_taken();
      run_branch(1'b1, 1'b0);
   endtask

   task automatic test_not_taken();
      run_branch(1'b0, 1'b0);
   endtask

   task automatic test_back_to_back();
      run_branch(1'b1, 1'b0);
      run_branch(1'b0, 1'b0);
      run_branch(1'b1, 1'b0);
   endtask

   task automatic test_start_while_busy();
      run_branch(1'b1, 1'b1);
   endtask

   task automatic test_illegal();
      start = 1'b1;
      ir    = IR_BAD;
      tick();
      start = 1'b0;
      ir    = IR_BR;
      exp_ill = 1'b1;
      n_cmp++;
      if (bif.illegal !== 1'b1 || bif.busy !== 1'b0 || stb16() !== P_IDLE) begin
         n_err++;
         $display("FAIL illegal_set: got ill %b busy %b stb %b, want 1 0 %b",
                  bif.illegal, bif.busy, stb16(), P_IDLE);
      end
      tick();
      tick();
      n_cmp++;
      if (bif.illegal !== 1'b1 || bif.busy !== 1'b0) begin
         n_err++;
         $display("FAIL illegal_sticky: got ill %b busy %b, want 1 0", bif.illegal, bif.busy);
      end
      run_branch(1'b1, 1'b0);
   endtask

   task automatic test_mid_reset();
      start = 1'b1;
      ir    = IR_BR;
      tick();
      start = 1'b0;
      tick();
      con_in = 1'b1;
      tick();
      #2;
      clr = 1'b1;
      #1;
      exp_cnt = 0;
      exp_ill = 1'b0;
      n_cmp++;
      if (stb16() !== P_IDLE || bif.busy !== 1'b0 || bif.taken_cnt !== 16'd0 ||
          bif.illegal !== 1'b0 || bif.taken !== 1'b0) begin
         n_err++;
         $display("FAIL mid_reset: got stb %b busy %b cnt %0d ill %b taken %b, want all 0",
                  stb16(), bif.busy, bif.taken_cnt, bif.illegal, bif.taken);
      end
      #1;
      clr = 1'b0;
      for (int i = 0; i < 4; i++) begin
         tick();
         n_cmp++;
         if (bif.PCin !== 1'b0 || bif.busy !== 1'b0 || bif.taken_cnt !== 16'd0) begin
            n_err++;
            $display("FAIL post_reset[%0d]: got PCin %b busy %b cnt %0d, want 0 0 0",
                     i, bif.PCin, bif.busy, bif.taken_cnt);
         end
      end
   endtask

   task automatic test_saturation();
      for (int i = 0; i < 17; i++)
         run_branch(1'b1, 1'b0);
      n_cmp++;
      if (bif4.taken_cnt !== 4'd15 || bif.taken_cnt !== 16'd17) begin
         n_err++;
         $display("FAIL saturation: got cnt4 %0d cnt16 %0d, want 15 17",
                  bif4.taken_cnt, bif.taken_cnt);
      end
   endtask

   initial begin
      n_cmp = 0;
      n_err = 0;
      test_reset();
      test_taken();
      test_not_taken();
      test_back_to_back();
      test_start_while_busy();
      test_illegal();
      test_mid_reset();
      test_saturation();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
